// File: rtl/uart_distance_rx_pkg.sv
// Shared definitions for the UART distance receiver.
// Holds the bit-period derivation, the ASCII constants the parser reacts to,
// the byte receiver state encoding and a byte classifier used by the parser.
package uart_distance_rx_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  // Byte receiver state encoding (kept as plain constants for legacy tools)
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t ST_IDLE      = 3'd0;
  localparam rx_state_t ST_START     = 3'd1;
  localparam rx_state_t ST_DATA      = 3'd2;
  localparam rx_state_t ST_STOP      = 3'd3;
  localparam rx_state_t ST_WAIT_HIGH = 3'd4;

  typedef enum logic [1:0] {
    CLS_DIGIT,
    CLS_CR,
    CLS_LF,
    CLS_OTHER
  } byte_class_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic byte_class_t classify(input logic [7:0] b);
    if (b >= ASCII_ZERO && b <= ASCII_NINE) return CLS_DIGIT;
    if (b == ASCII_CR)                      return CLS_CR;
    if (b == ASCII_LF)                      return CLS_LF;
    return CLS_OTHER;
  endfunction

endpackage

// File: rtl/uart_distance_rx_if.sv
// Bundle of the serial input and the parsed-distance / status outputs.
//   uartrx     : raw serial line (idle high)
//   dist_cm    : last accepted distance in cm
//   dist_valid : one-cycle pulse when dist_cm updates
//   parse_err  : one-cycle pulse on LF ending a rejected line
//   frame_err  : one-cycle pulse on a low stop bit
//   rx_busy    : receiver is inside a frame
// master = the receiver, slave = whoever drives the line and consumes results.
interface uart_distance_rx_if;
  logic        uartrx;
  logic [15:0] dist_cm;
  logic        dist_valid;
  logic        parse_err;
  logic        frame_err;
  logic        rx_busy;

  modport master (
    input  uartrx,
    output dist_cm, dist_valid, parse_err, frame_err, rx_busy
  );

  modport slave (
    output uartrx,
    input  dist_cm, dist_valid, parse_err, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with a 2-flop input synchronizer.
//   hw_clk, rst : clock, async active-high reset
//   uartrx      : raw serial line
//   rx_byte     : last good byte, valid while byte_stb is high
//   byte_stb    : one-cycle strobe the cycle after a good stop bit
//   frame_err   : one-cycle pulse when the stop bit samples low
//   busy        : high whenever the receiver is not in IDLE
//
// state      | meaning
// IDLE       | waiting for a low level on the synchronized line
// START      | half a bit period in, confirm the start bit is still low
// DATA       | sample 8 data bits, LSB first, one bit period apart
// STOP       | sample the stop bit; high -> byte, low -> frame error
// WAIT_HIGH  | after a frame error, wait for the line to return high
module uart_rx_byte
  import uart_distance_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       hw_clk,
  input  logic       rst,
  input  logic       uartrx,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       frame_err,
  output logic       busy
);

  localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] BIT_LOAD  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta;
  logic             rx_sync;
  rx_state_t        state;
  logic [TMR_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Reset to the idle level so the line does not look like a start bit.
  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uartrx;
      rx_sync <= rx_meta;
    end
  end

  // The timer is a down-counter; each state acts when it reaches zero.
  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_sync) begin
            state <= ST_START;
            timer <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (timer == '0) begin
            if (!rx_sync) begin
              state   <= ST_DATA;
              timer   <= BIT_LOAD;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_DATA: begin
          if (timer == '0) begin
            shreg <= {rx_sync, shreg[7:1]};
            timer <= BIT_LOAD;
            if (bit_idx == 3'd7) state <= ST_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_STOP: begin
          if (timer == '0) begin
            if (rx_sync) begin
              rx_byte  <= shreg;
              byte_stb <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_HIGH;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/uart_distance_rx.sv
// Receives ASCII decimal distance lines ("123\r\n") over 8N1 UART and
// presents the last accepted value in centimetres.
//   hw_clk, rst : clock, async active-high reset
//   bus         : serial input and result/status outputs (master side)
// A line is accepted when it holds 1..MAX_DIGITS digits, optional CRs and
// nothing else, and no frame error occurred while it was being received.
module uart_distance_rx
  import uart_distance_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int MAX_DIGITS = 3
) (
  input  logic                hw_clk,
  input  logic                rst,
  uart_distance_rx_if.master  bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  logic [7:0]       rx_byte;
  logic             byte_stb;
  logic             rx_frame_err;
  logic             rx_busy;

  logic [9:0]       acc;
  logic [CNT_W-1:0] cnt;
  logic             line_bad;
  logic [15:0]      dist_q;
  logic             dist_valid_q;
  logic             parse_err_q;
  logic [13:0]      acc_next;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .hw_clk    (hw_clk),
    .rst       (rst),
    .uartrx    (bus.uartrx),
    .rx_byte   (rx_byte),
    .byte_stb  (byte_stb),
    .frame_err (rx_frame_err),
    .busy      (rx_busy)
  );

  // Wide intermediate so the multiply does not wrap before truncation to acc.
  assign acc_next = 14'(acc) * 14'd10 + {10'd0, rx_byte[3:0]};

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      line_bad     <= 1'b0;
      dist_q       <= '0;
      dist_valid_q <= 1'b0;
      parse_err_q  <= 1'b0;
    end else begin
      dist_valid_q <= 1'b0;
      parse_err_q  <= 1'b0;
      // frame_err and byte_stb are never high together.
      if (rx_frame_err) begin
        line_bad <= 1'b1;
      end else if (byte_stb) begin
        case (classify(rx_byte))
          CLS_DIGIT: begin
            if (cnt < CNT_MAX) begin
              acc <= acc_next[9:0];
              cnt <= cnt + 1'b1;
            end else begin
              line_bad <= 1'b1;
            end
          end
          CLS_CR: ;
          CLS_LF: begin
            if (cnt != '0 && !line_bad) begin
              dist_q       <= {6'b0, acc};
              dist_valid_q <= 1'b1;
            end else begin
              parse_err_q <= 1'b1;
            end
            acc      <= '0;
            cnt      <= '0;
            line_bad <= 1'b0;
          end
          default: line_bad <= 1'b1;
        endcase
      end
    end
  end

  assign bus.dist_cm    = dist_q;
  assign bus.dist_valid = dist_valid_q;
  assign bus.parse_err  = parse_err_q;
  assign bus.frame_err  = rx_frame_err;
  assign bus.rx_busy    = rx_busy;

endmodule

// File: doc/uart_distance_rx.md
UART_DISTANCE_RX -- requirements
Module: uart_distance_rx

Interface
REQ-001 Parameter CLK_FREQ, default 12_000_000: hw_clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600: serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (1250 at defaults).
REQ-003 Parameter MAX_DIGITS, default 3: maximum decimal digits accepted per line.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 hw_clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 uartrx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-008 dist_cm  output  16  last successfully parsed distance in cm; held between updates.
REQ-009 dist_valid  output  1  one-cycle pulse; dist_cm updated in the same cycle.
REQ-010 parse_err  output  1  one-cycle pulse on LF terminating a rejected line.
REQ-011 frame_err  output  1  one-cycle pulse when a sampled stop bit is 0.
REQ-012 rx_busy  output  1  high from start-bit detection until return to IDLE.

Function
REQ-013 uartrx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value only.
REQ-014 Byte receiver states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: synchronized line low -> START, bit timer cleared.
REQ-016 START: after CLKS_PER_BIT/2 cycles, sample; low -> DATA; high -> IDLE (glitch rejected, no output).
REQ-017 DATA: sample every CLKS_PER_BIT cycles, 8 samples, first sample = bit 0; then STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, sample; high -> internal byte strobe next cycle, go IDLE; low -> frame_err pulse, byte discarded, go WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until synchronized line high, then IDLE (no restart on a held-low line).
REQ-020 Parser holds accumulator acc (10 bits), digit count cnt (0..MAX_DIGITS), flag line_bad.
REQ-021 Byte 0x30-0x39 with cnt<MAX_DIGITS: acc <= acc*10 + (byte-0x30), cnt+1.
REQ-022 Digit byte with cnt==MAX_DIGITS: line_bad set, acc unchanged.
REQ-023 Byte 0x0D: ignored.
REQ-024 Any other byte except 0x0A: line_bad set.
REQ-025 frame_err event: line_bad set.
REQ-026 Byte 0x0A with cnt>0 and line_bad clear: dist_cm <= {6'b0, acc}, dist_valid pulse, 1 cycle after the LF byte strobe.
REQ-027 Byte 0x0A with cnt==0 or line_bad set: parse_err pulse, dist_cm unchanged.
REQ-028 Every 0x0A: acc, cnt, line_bad cleared in the same cycle.
REQ-029 Leading zeros count as digits ("007" = 7, three digits).
REQ-030 dist_valid and parse_err SHALL never assert in the same cycle.

Reset
REQ-031 On rst: receiver to IDLE, synchronizer flops to 1, timers 0, acc/cnt/line_bad 0, dist_cm 0, dist_valid/parse_err/frame_err/rx_busy 0.
REQ-032 Reset mid-frame abandons the byte; the next falling edge after release starts a fresh frame.

Structure
REQ-033 Shared package holds CLKS_PER_BIT derivation, ASCII constants (0x30, 0x39, 0x0A, 0x0D) and the receiver state encoding.
REQ-034 Byte receiver is sub-module uart_rx_byte (outputs byte, byte strobe, frame_err, busy); the parser lives in uart_distance_rx.

Verification
REQ-035 Send "123\n" at 9600 baud -> one dist_valid pulse, dist_cm=123, no error pulses.
REQ-036 Send "007\r\n" -> dist_cm=7; then "1234\n" -> parse_err pulse, dist_cm stays 7.
REQ-037 Drive uartrx low for 300 cycles then high -> no byte, no frame_err, rx_busy back low within 626 cycles.
REQ-038 Send '4' with stop bit 0, hold line high, then "\n" -> frame_err then parse_err; then "45\n" -> dist_cm=45.
REQ-039 Send "\n" alone and "1a2\n" -> parse_err each, dist_cm unchanged.
REQ-040 Assert rst during DATA of '9' of "99\n", release, send "56\n" -> dist_cm=56, no spurious pulses.
